// File: rtl/param_reg_fifo_if.sv
// Producer/consumer bus of param_reg_fifo; WIDTH/DEPTH must match the FIFO instance.
// master = producer/consumer side, slave = the FIFO itself.
interface param_reg_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             read;
  logic             write;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output read, write, in,
    input  out, valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  read, write, in,
    output out, valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_reg_fifo.sv
// DEPTH-entry FIFO of WIDTH-bit words with registered read data, status and error pulses.
// Optional macro PARAM_REG_FIFO_FALLTHROUGH_EN: read+write while empty passes 'in' straight to 'out'.
module param_reg_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  param_reg_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             full_i;
  logic             empty_i;
  logic             push_ok;
  logic             pop_ok;
  logic             pass_through;

  assign full_i    = (count_q == FULL_COUNT);
  assign empty_i   = (count_q == '0);
  assign bus.full  = full_i;
  assign bus.empty = empty_i;
  assign bus.count = count_q;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    pass_through = 1'b0;
`ifdef PARAM_REG_FIFO_FALLTHROUGH_EN
    pass_through = bus.read && bus.write && empty_i;
`endif
    pop_ok  = bus.read && !empty_i;
    push_ok = bus.write && (!full_i || bus.read) && !pass_through;
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      bus.out       <= '0;
      bus.valid     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // When full, rd_ptr == wr_ptr; the read sees the old word before the write lands.
      if (pop_ok) begin
        bus.out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end else if (pass_through) begin
        bus.out <= bus.in;
      end
      bus.valid     <= pop_ok || pass_through;
      bus.overflow  <= bus.write && full_i && !bus.read;
      bus.underflow <= bus.read && empty_i && !pass_through;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_param_reg_fifo.sv
// Self-checking bench for param_reg_fifo (DEPTH=4, WIDTH=16): directed plan plus random traffic
// compared every cycle against a queue-based reference model.
module tb_param_reg_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  param_reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_out;
  logic             exp_valid;
  logic             exp_ovf;
  logic             exp_unf;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at t=%0t", tag, got, want, $time);
    end
  endtask

  // One clock of stimulus; the model applies pop-before-push so a full read+write pops the oldest word.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr, input logic [WIDTH-1:0] din);
    bit was_empty;
    bit was_full;
    @(negedge clk);
    reset     = rst;
    bus.read  = rd;
    bus.write = wr;
    bus.in    = din;
    @(posedge clk);
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    if (rst) begin
      model_q.delete();
      exp_out = '0;
    end else if (rd && wr && was_empty) begin
`ifdef PARAM_REG_FIFO_FALLTHROUGH_EN
      exp_out   = din;
      exp_valid = 1'b1;
`else
      model_q.push_back(din);
      exp_unf = 1'b1;
`endif
    end else begin
      if (rd) begin
        if (was_empty) exp_unf = 1'b1;
        else begin
          exp_out   = model_q.pop_front();
          exp_valid = 1'b1;
        end
      end
      if (wr) begin
        if (was_full && !rd) exp_ovf = 1'b1;
        else model_q.push_back(din);
      end
    end
    #1;
    checkOutput("out",       32'(bus.out),       32'(exp_out));
    checkOutput("valid",     32'(bus.valid),     32'(exp_valid));
    checkOutput("count",     32'(bus.count),     32'(model_q.size()));
    checkOutput("full",      32'(bus.full),      32'(model_q.size() == DEPTH));
    checkOutput("empty",     32'(bus.empty),     32'(model_q.size() == 0));
    checkOutput("overflow",  32'(bus.overflow),  32'(exp_ovf));
    checkOutput("underflow", 32'(bus.underflow), 32'(exp_unf));
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic popExpect(input string tag, input logic [WIDTH-1:0] want);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput(tag, 32'(bus.out), 32'(want));
    checkOutput({tag, "_valid"}, 32'(bus.valid), 32'(1));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_out   = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    reset     = 1'b1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.in    = '0;

    $display("[TB] reset and basic order");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("rst_empty", 32'(bus.empty), 32'(1));
    checkOutput("rst_out",   32'(bus.out),   32'(0));
    pushWord(16'h1111);
    pushWord(16'h2222);
    pushWord(16'h3333);
    popExpect("t1_pop0", 16'h1111);
    popExpect("t1_pop1", 16'h2222);
    popExpect("t1_pop2", 16'h3333);
    checkOutput("t1_count", 32'(bus.count), 32'(0));
    checkOutput("t1_empty", 32'(bus.empty), 32'(1));

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 4; i++) pushWord(16'hA000 + 16'(i));
    checkOutput("t2_full",  32'(bus.full),  32'(1));
    checkOutput("t2_count", 32'(bus.count), 32'(4));
    pushWord(16'hA005);
    checkOutput("t2_ovf",   32'(bus.overflow), 32'(1));
    checkOutput("t2_cnt4",  32'(bus.count),    32'(4));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("t2_ovf_pulse", 32'(bus.overflow), 32'(0));
    for (int i = 1; i <= 4; i++) popExpect("t2_pop", 16'hA000 + 16'(i));
    checkOutput("t2_empty", 32'(bus.empty), 32'(1));

    $display("[TB] pointer wrap");
    for (int i = 0; i < 3; i++) pushWord(16'h7000 + 16'(i));
    for (int i = 0; i < 3; i++) popExpect("t3_pre", 16'h7000 + 16'(i));
    for (int i = 1; i <= 4; i++) pushWord(16'hB000 + 16'(i));
    for (int i = 1; i <= 4; i++) popExpect("t3_pop", 16'hB000 + 16'(i));

    $display("[TB] full with read and write");
    for (int i = 1; i <= 4; i++) pushWord(16'hC000 + 16'(i));
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hC0DE);
    checkOutput("t4_oldest", 32'(bus.out),      32'(16'hC001));
    checkOutput("t4_count",  32'(bus.count),    32'(4));
    checkOutput("t4_no_ovf", 32'(bus.overflow), 32'(0));
    popExpect("t4_d0", 16'hC002);
    popExpect("t4_d1", 16'hC003);
    popExpect("t4_d2", 16'hC004);
    popExpect("t4_last", 16'hC0DE);

    $display("[TB] empty with read and write");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5A5A);
`ifdef PARAM_REG_FIFO_FALLTHROUGH_EN
    checkOutput("t5_out",   32'(bus.out),       32'(16'h5A5A));
    checkOutput("t5_valid", 32'(bus.valid),     32'(1));
    checkOutput("t5_count", 32'(bus.count),     32'(0));
    checkOutput("t5_unf",   32'(bus.underflow), 32'(0));
`else
    checkOutput("t5_unf",   32'(bus.underflow), 32'(1));
    checkOutput("t5_valid", 32'(bus.valid),     32'(0));
    checkOutput("t5_count", 32'(bus.count),     32'(1));
    popExpect("t5_pop", 16'h5A5A);
`endif

    $display("[TB] reset mid-stream");
    pushWord(16'hD001);
    pushWord(16'hD002);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t6_out",   32'(bus.out),   32'(0));
    checkOutput("t6_valid", 32'(bus.valid), 32'(0));
    checkOutput("t6_count", 32'(bus.count), 32'(0));
    checkOutput("t6_empty", 32'(bus.empty), 32'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("t6_unf", 32'(bus.underflow), 32'(1));

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      int rd_bias;
      rd_bias = (n / 100) % 2 == 0 ? 35 : 65;
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 99) < rd_bias,
                    $urandom_range(0, 99) < (100 - rd_bias),
                    WIDTH'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
